// File: rtl/player_controller_pkg.sv
// Shared action codes, map bounds, FSM encoding and key decode for the player controller.
package player_controller_pkg;

  localparam int unsigned X_W         = 9;
  localparam int unsigned Y_W         = 8;
  localparam int unsigned ACT_W       = 3;
  localparam int unsigned HEALTH_W    = 3;

  localparam int unsigned MAP_W       = 256;
  localparam int unsigned MAP_H       = 176;
  localparam int unsigned SPRITE_SIZE = 16;
  localparam int unsigned MAX_X       = MAP_W - SPRITE_SIZE;
  localparam int unsigned MAX_Y       = MAP_H - SPRITE_SIZE;

  typedef enum logic [ACT_W-1:0] {
    ACT_NONE   = 3'd0,
    ACT_ATTACK = 3'd1,
    ACT_UP     = 3'd2,
    ACT_DOWN   = 3'd3,
    ACT_LEFT   = 3'd4,
    ACT_RIGHT  = 3'd5
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DEAD   = 3'd4
  } state_e;

  typedef struct packed {
    logic attack;
    logic up;
    logic down;
    logic left;
    logic right;
  } keys_t;

  // Priority attack > up > down > left > right; attack only when the attack timer is idle.
  function automatic action_e decode_keys(input keys_t keys, input logic attack_ready);
    action_e act;
    act = ACT_NONE;
    if (keys.attack && attack_ready) act = ACT_ATTACK;
    else if (keys.up)                act = ACT_UP;
    else if (keys.down)              act = ACT_DOWN;
    else if (keys.left)              act = ACT_LEFT;
    else if (keys.right)             act = ACT_RIGHT;
    return act;
  endfunction

  function automatic logic is_move(input action_e act);
    return (act == ACT_UP) || (act == ACT_DOWN) || (act == ACT_LEFT) || (act == ACT_RIGHT);
  endfunction

endpackage

// File: rtl/player_controller_frame_timer.sv
// Loadable down-counter in frame steps with a registered non-zero flag.
module player_controller_frame_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         active_o
);

  logic [W-1:0] count_q, count_d;
  logic         active_q, active_d;

  // Load wins over decrement; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
    active_d = (count_d != '0);
  end

  // Counter and flag registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/player_controller.sv
// Per-frame player step: key decode, detector handshake, move/knockback commit, health.
module player_controller
  import player_controller_pkg::*;
#(
  parameter int unsigned START_X       = 120,
  parameter int unsigned START_Y       = 80,
  parameter int unsigned ATTACK_FRAMES = 8,
  parameter int unsigned INVULN_FRAMES = 32,
  parameter int unsigned KNOCKBACK_PX  = 8,
  parameter int unsigned MAX_HEALTH    = 3,
  parameter int unsigned DONE_TIMEOUT  = 32
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic                key_up,
  input  logic                key_down,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                key_attack,
  input  logic                c_map_collision,
  input  logic                c_e1_collision,
  input  logic                collision_done,
  output logic [X_W-1:0]      char_x,
  output logic [Y_W-1:0]      char_y,
  output logic [ACT_W-1:0]    direction_char,
  output logic [ACT_W-1:0]    facing_char,
  output logic                attack,
  output logic                collision_init,
  output logic                collision_enable,
  output logic [HEALTH_W-1:0] health,
  output logic                invuln,
  output logic                dead,
  output logic                step_done
);

  localparam int unsigned ATK_W  = $clog2(ATTACK_FRAMES + 1);
  localparam int unsigned INV_W  = $clog2(INVULN_FRAMES + 1);
  localparam int unsigned WAIT_W = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned XK_W   = X_W + 1;
  localparam int unsigned YK_W   = Y_W + 1;

  state_e                state_q;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  action_e               dir_q;
  action_e               facing_q, facing_d;
  logic [HEALTH_W-1:0]   health_q, health_d;
  logic                  init_q, en_q, dead_q, step_done_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic                  map_q, e1_q;

  keys_t                 keys_c;
  action_e               action_c;
  logic                  atk_active, inv_active;
  logic                  atk_load_c, commit_c, hit_c, inv_load_c;

  logic [X_W-1:0]        kb_right_x, kb_left_x;
  logic [XK_W-1:0]       kb_left_sum;
  logic [Y_W-1:0]        kb_down_y, kb_up_y;
  logic [YK_W-1:0]       kb_up_sum;

  assign keys_c   = {key_attack, key_up, key_down, key_left, key_right};
  assign action_c = decode_keys(keys_c, !atk_active);

  assign commit_c   = (state_q == ST_COMMIT);
  assign atk_load_c = (state_q == ST_IDLE) && frame_tick && (action_c == ACT_ATTACK);
  assign hit_c      = e1_q && !inv_active;
  assign inv_load_c = commit_c && hit_c;

  // Attack window: loaded when an attack is latched, counted down per committed step.
  player_controller_frame_timer #(.W(ATK_W)) u_attack_timer (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (atk_load_c),
    .load_val_i (ATK_W'(ATTACK_FRAMES)),
    .dec_i      (commit_c),
    .active_o   (atk_active)
  );

  // Invulnerability window: loaded on an unprotected hit, counted down per committed step.
  player_controller_frame_timer #(.W(INV_W)) u_invuln_timer (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (inv_load_c),
    .load_val_i (INV_W'(INVULN_FRAMES)),
    .dec_i      (commit_c),
    .active_o   (inv_active)
  );

  // Knockback targets, clamped to the playfield.
  assign kb_right_x  = (x_q >= X_W'(KNOCKBACK_PX)) ? (x_q - X_W'(KNOCKBACK_PX)) : '0;
  assign kb_left_sum = XK_W'(x_q) + XK_W'(KNOCKBACK_PX);
  assign kb_left_x   = (kb_left_sum > XK_W'(MAX_X)) ? X_W'(MAX_X) : kb_left_sum[X_W-1:0];
  assign kb_down_y   = (y_q >= Y_W'(KNOCKBACK_PX)) ? (y_q - Y_W'(KNOCKBACK_PX)) : '0;
  assign kb_up_sum   = YK_W'(y_q) + YK_W'(KNOCKBACK_PX);
  assign kb_up_y     = (kb_up_sum > YK_W'(MAX_Y)) ? Y_W'(MAX_Y) : kb_up_sum[Y_W-1:0];

  // Commit datapath: facing, 1 px move, then knockback overriding the move on a hit.
  always_comb begin
    facing_d = facing_q;
    x_d      = x_q;
    y_d      = y_q;
    health_d = health_q;
    if (is_move(dir_q)) begin
      facing_d = dir_q;
    end
    if (is_move(dir_q) && !map_q) begin
      case (dir_q)
        ACT_UP:    if (y_q != '0)           y_d = y_q - Y_W'(1);
        ACT_DOWN:  if (y_q < Y_W'(MAX_Y))   y_d = y_q + Y_W'(1);
        ACT_LEFT:  if (x_q != '0)           x_d = x_q - X_W'(1);
        ACT_RIGHT: if (x_q < X_W'(MAX_X))   x_d = x_q + X_W'(1);
        default: ;
      endcase
    end
    if (hit_c) begin
      x_d = x_q;
      y_d = y_q;
      if (health_q != '0) begin
        health_d = health_q - HEALTH_W'(1);
      end
      case (facing_d)
        ACT_UP:    y_d = kb_up_y;
        ACT_DOWN:  y_d = kb_down_y;
        ACT_LEFT:  x_d = kb_left_x;
        ACT_RIGHT: x_d = kb_right_x;
        default: ;
      endcase
    end
  end

  // Step sequencer with registered detector handshake and player state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      x_q         <= X_W'(START_X);
      y_q         <= Y_W'(START_Y);
      dir_q       <= ACT_NONE;
      facing_q    <= ACT_DOWN;
      health_q    <= HEALTH_W'(MAX_HEALTH);
      init_q      <= 1'b0;
      en_q        <= 1'b0;
      dead_q      <= 1'b0;
      step_done_q <= 1'b0;
      wait_cnt_q  <= '0;
      map_q       <= 1'b0;
      e1_q        <= 1'b0;
    end else begin
      init_q      <= 1'b0;
      step_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            dir_q   <= action_c;
            init_q  <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          en_q       <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (collision_done) begin
            map_q   <= c_map_collision;
            e1_q    <= c_e1_collision;
            en_q    <= 1'b0;
            state_q <= ST_COMMIT;
          end else if (wait_cnt_q == WAIT_W'(DONE_TIMEOUT - 1)) begin
            // A silent detector is treated as a blocked move with no enemy contact.
            map_q   <= 1'b1;
            e1_q    <= 1'b0;
            en_q    <= 1'b0;
            state_q <= ST_COMMIT;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_COMMIT: begin
          x_q         <= x_d;
          y_q         <= y_d;
          facing_q    <= facing_d;
          health_q    <= health_d;
          step_done_q <= 1'b1;
          if (health_d == '0) begin
            dead_q  <= 1'b1;
            state_q <= ST_DEAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DEAD: begin
          dead_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign char_x           = x_q;
  assign char_y           = y_q;
  assign direction_char   = dir_q;
  assign facing_char      = facing_q;
  assign attack           = atk_active;
  assign collision_init   = init_q;
  assign collision_enable = en_q;
  assign health           = health_q;
  assign invuln           = inv_active;
  assign dead             = dead_q;
  assign step_done        = step_done_q;

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller with a behavioural model and expected-result queue.
module tb_player_controller;

  localparam int START_X = 120;
  localparam int START_Y = 80;
  localparam int ATTACK_FRAMES = 8;
  localparam int INVULN_FRAMES = 32;
  localparam int KNOCKBACK_PX = 8;
  localparam int MAX_HEALTH = 3;
  localparam int DONE_TIMEOUT = 32;

  localparam int A_NONE = 0, A_ATTACK = 1, A_UP = 2, A_DOWN = 3, A_LEFT = 4, A_RIGHT = 5;
  localparam logic [4:0] K_NONE = 5'b00000, K_R = 5'b00001, K_L = 5'b00010,
                         K_D = 5'b00100, K_U = 5'b01000, K_A = 5'b10000;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_attack = 1'b0;
  logic c_map_collision = 1'b0, c_e1_collision = 1'b0, collision_done = 1'b0;
  logic [8:0] char_x;
  logic [7:0] char_y;
  logic [2:0] direction_char, facing_char, health;
  logic attack, collision_init, collision_enable, invuln, dead, step_done;

  always #5 clock = ~clock;

  player_controller dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_attack(key_attack), .c_map_collision(c_map_collision), .c_e1_collision(c_e1_collision),
    .collision_done(collision_done), .char_x(char_x), .char_y(char_y),
    .direction_char(direction_char), .facing_char(facing_char), .attack(attack),
    .collision_init(collision_init), .collision_enable(collision_enable), .health(health),
    .invuln(invuln), .dead(dead), .step_done(step_done)
  );

  typedef struct {
    int x; int y; int face; int health; int dir;
    bit atk; bit inv; bit dead;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  int m_x, m_y, m_face, m_health, m_atk, m_inv;
  bit m_dead;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, passed=%0d checks=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_face = A_DOWN; m_health = MAX_HEALTH;
    m_atk = 0; m_inv = 0; m_dead = 1'b0;
  endtask

  function automatic int model_action(input logic [4:0] k);
    if (k[4] && m_atk == 0) return A_ATTACK;
    if (k[3]) return A_UP;
    if (k[2]) return A_DOWN;
    if (k[1]) return A_LEFT;
    if (k[0]) return A_RIGHT;
    return A_NONE;
  endfunction

  task automatic model_commit(input int act, input bit map_f, input bit e1_f, output exp_t e);
    int nx, ny;
    bit mv;
    mv = (act >= A_UP);
    nx = m_x; ny = m_y;
    if (mv) m_face = act;
    if (mv && !map_f) begin
      if (act == A_UP && ny > 0) ny--;
      if (act == A_DOWN && ny < 160) ny++;
      if (act == A_LEFT && nx > 0) nx--;
      if (act == A_RIGHT && nx < 240) nx++;
    end
    if (e1_f && m_inv == 0) begin
      nx = m_x; ny = m_y;
      if (m_health > 0) m_health--;
      m_inv = INVULN_FRAMES;
      if (m_face == A_RIGHT) nx = (m_x - KNOCKBACK_PX < 0) ? 0 : m_x - KNOCKBACK_PX;
      if (m_face == A_LEFT)  nx = (m_x + KNOCKBACK_PX > 240) ? 240 : m_x + KNOCKBACK_PX;
      if (m_face == A_UP)    ny = (m_y + KNOCKBACK_PX > 160) ? 160 : m_y + KNOCKBACK_PX;
      if (m_face == A_DOWN)  ny = (m_y - KNOCKBACK_PX < 0) ? 0 : m_y - KNOCKBACK_PX;
    end else if (m_inv > 0) begin
      m_inv--;
    end
    if (m_atk > 0) m_atk--;
    m_x = nx; m_y = ny;
    m_dead = (m_health == 0);
    e.x = m_x; e.y = m_y; e.face = m_face; e.health = m_health; e.dir = act;
    e.atk = (m_atk != 0); e.inv = (m_inv != 0); e.dead = m_dead;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"}, char_x, START_X);
    check({tag, "_y"}, char_y, START_Y);
    check({tag, "_dir"}, direction_char, A_NONE);
    check({tag, "_facing"}, facing_char, A_DOWN);
    check({tag, "_health"}, health, MAX_HEALTH);
    check({tag, "_attack"}, attack, 0);
    check({tag, "_invuln"}, invuln, 0);
    check({tag, "_dead"}, dead, 0);
    check({tag, "_init"}, collision_init, 0);
    check({tag, "_enable"}, collision_enable, 0);
    check({tag, "_step_done"}, step_done, 0);
  endtask

  task automatic wait_step_done();
    exp_t e;
    int i;
    i = 0;
    while (!step_done && i < 10) begin
      @(negedge clock);
      i++;
    end
    check("step_done_seen", step_done, 1);
    check("commit_latency", i, 1);
    if (step_done && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("char_x", char_x, e.x);
      check("char_y", char_y, e.y);
      check("facing", facing_char, e.face);
      check("health", health, e.health);
      check("dir_stable", direction_char, e.dir);
      check("attack", attack, e.atk);
      check("invuln", invuln, e.inv);
      check("dead", dead, e.dead);
    end
    @(negedge clock);
    check("step_done_pulse", step_done, 0);
  endtask

  task automatic run_step(input logic [4:0] k, input bit mf, input bit ef, input int lat,
                          input bit give_done, input bit tick_in_wait);
    int act;
    int en_cycles;
    exp_t e;
    @(negedge clock);
    {key_attack, key_up, key_down, key_left, key_right} = k;
    act = model_action(k);
    if (act == A_ATTACK) m_atk = ATTACK_FRAMES;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    check("req_init", collision_init, 1);
    check("req_dir", direction_char, act);
    check("req_attack", attack, m_atk != 0);
    check("req_enable", collision_enable, 0);
    @(negedge clock);
    check("wait_enable", collision_enable, 1);
    check("wait_init", collision_init, 0);
    if (give_done) begin
      repeat (lat) @(negedge clock);
      collision_done = 1'b1;
      c_map_collision = mf;
      c_e1_collision = ef;
      model_commit(act, mf, ef, e);
      sb_q.push_back(e);
      @(negedge clock);
      collision_done = 1'b0;
      c_map_collision = 1'b0;
      c_e1_collision = 1'b0;
    end else begin
      en_cycles = 1;
      if (tick_in_wait) frame_tick = 1'b1;
      model_commit(act, 1'b1, 1'b0, e);
      sb_q.push_back(e);
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        frame_tick = 1'b0;
        if (!collision_enable) break;
        en_cycles++;
      end
      check("timeout_wait_cycles", en_cycles, DONE_TIMEOUT);
    end
    wait_step_done();
  endtask

  initial begin
    bit seen_init, seen_done;

    // Reset state
    model_reset();
    repeat (3) @(negedge clock);
    check_reset("in_reset");
    resetn = 1'b1;
    @(negedge clock);
    check_reset("after_reset");

    // Single right move
    run_step(K_R, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    check("right_x_121", char_x, 121);
    check("right_facing", facing_char, A_RIGHT);

    // Attack with left held: attack step, then left moves while the timer runs, then a new attack
    run_step(K_A | K_L, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    check("attack_x_unchanged", char_x, 121);
    check("attack_high", attack, 1);
    repeat (7) run_step(K_A | K_L, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("attack_expired", attack, 0);
    check("left_moves_x", char_x, 114);
    run_step(K_A | K_L, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("reattack_dir", direction_char, A_ATTACK);

    // Walk to the top edge, then push against it
    while (m_y > 0) run_step(K_U, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    run_step(K_U, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    check("top_edge_y", char_y, 0);
    check("top_edge_facing", facing_char, A_UP);

    // Walk to x=4, then take a hit facing right
    while (m_x > 4) run_step(K_L, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    run_step(K_R, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    check("hit1_health", health, 2);
    check("hit1_x_clamped", char_x, 0);
    check("hit1_invuln", invuln, 1);
    run_step(K_R, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    check("invuln_hit_health", health, 2);
    repeat (INVULN_FRAMES - 1) run_step(K_NONE, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("invuln_expired", invuln, 0);

    // Detector silent, with a stray tick during WAIT
    run_step(K_R, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("timeout_x_hold", char_x, 1);

    // Second hit with simultaneous map collision, then third hit
    run_step(K_U, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    check("hit2_health", health, 1);
    check("hit2_y", char_y, 8);
    repeat (INVULN_FRAMES) run_step(K_NONE, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    run_step(K_L, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    check("hit3_health", health, 0);
    check("hit3_dead", dead, 1);

    // Dead: ticks ignored
    @(negedge clock);
    {key_attack, key_up, key_down, key_left, key_right} = K_R;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    seen_init = 1'b0;
    seen_done = 1'b0;
    repeat (10) begin
      if (collision_init) seen_init = 1'b1;
      if (step_done) seen_done = 1'b1;
      @(negedge clock);
    end
    check("dead_no_init", seen_init, 0);
    check("dead_no_step", seen_done, 0);
    check("dead_x_hold", char_x, m_x);
    check("dead_held", dead, 1);

    // Reset mid-step aborts without step_done
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    {key_attack, key_up, key_down, key_left, key_right} = K_R;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    repeat (3) @(negedge clock);
    check("midstep_enable", collision_enable, 1);
    resetn = 1'b0;
    #1;
    check_reset("midstep_reset");
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (step_done) seen_done = 1'b1;
    end
    check("midstep_no_step_done", seen_done, 0);
    model_reset();
    run_step(K_R, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    check("post_reset_x", char_x, 121);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
